// File: rtl/ext_mem_responder.sv
// External-memory responder for one HLS master memory channel: serves held
// read/write requests from a local byte array after a fixed latency, plus a host byte port.
module ext_mem_responder #(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 16,
  parameter int          SIZE_W      = 5,
  parameter int          MEM_BYTES   = 1024,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int          READ_DELAY  = 2,
  parameter int          WRITE_DELAY = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         Mout_oe_ram,
  input  logic                         Mout_we_ram,
  input  logic [ADDR_W-1:0]            Mout_addr_ram,
  input  logic [DATA_W-1:0]            Mout_Wdata_ram,
  input  logic [SIZE_W-1:0]            Mout_data_ram_size,
  output logic [DATA_W-1:0]            M_Rdata_ram,
  output logic                         M_DataRdy,
  output logic                         err,
  input  logic                         host_en,
  input  logic                         host_we,
  input  logic [$clog2(MEM_BYTES)-1:0] host_addr,
  input  logic [7:0]                   host_wdata,
  output logic [7:0]                   host_rdata,
  output logic [1:0]                   dbg_state
);

  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam int NB    = DATA_W / 8;
  localparam int NBW   = SIZE_W - 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NBW-1:0]   nb_q, nb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [7:0]       host_rdata_q;
  logic [7:0]       mem [MEM_BYTES];

  logic              req, accept, req_err, size_bad, range_bad, wr_commit;
  logic [ADDR_W:0]   idx_ext;
  logic [ADDR_W+1:0] end_ext;
  logic [NBW-1:0]    req_nb;
  logic [DATA_W-1:0] rd_word;
  logic [IDX_W-1:0]  wr_idx [NB];

  // Handshake: the initiator raises oe or we and holds it (with address, size
  // and data) until it sees the one-cycle M_DataRdy pulse. A request present
  // on an edge where the FSM is IDLE, or is finishing its RESP cycle, is
  // accepted on that edge; inputs held afterwards are ignored.
  always_comb begin
    req       = Mout_oe_ram | Mout_we_ram;
    accept    = req && (state_q == S_IDLE || state_q == S_RESP);
    req_nb    = Mout_data_ram_size[SIZE_W-1:3];
    idx_ext   = {1'b0, Mout_addr_ram} - (ADDR_W+1)'(BASE_ADDR);
    end_ext   = {1'b0, idx_ext} + (ADDR_W+2)'(req_nb);
    size_bad  = (Mout_data_ram_size == '0) || (Mout_data_ram_size[2:0] != 3'd0) ||
                (32'(Mout_data_ram_size) > 32'(DATA_W));
    range_bad = idx_ext[ADDR_W] || (end_ext > (ADDR_W+2)'(MEM_BYTES));
    req_err   = (Mout_oe_ram & Mout_we_ram) | size_bad | range_bad;
    wr_commit = accept & Mout_we_ram & ~req_err & reset;
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NB; k++) begin
      wr_idx[k] = idx_ext[IDX_W-1:0] + IDX_W'(k);
      if (NBW'(k) < nb_q) rd_word[8*k +: 8] = mem[idx_q + IDX_W'(k)];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      nb_q         <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      nb_q    <= nb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (host_en && !host_we) host_rdata_q <= mem[host_addr];
    end
  end

  // Array is never reset; the accelerator write is issued last so it wins a same-byte collision.
  always_ff @(posedge clock) begin
    if (host_en && host_we) mem[host_addr] <= host_wdata;
    for (int k = 0; k < NB; k++) begin
      if (wr_commit && (NBW'(k) < req_nb)) mem[wr_idx[k]] <= Mout_Wdata_ram[8*k +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nb_d    = nb_q;
    rdata_d = '0;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (req) begin
          idx_d = idx_ext[IDX_W-1:0];
          nb_d  = req_nb;
          err_d = err_q | req_err;
          // Errored requests complete on the write timing and never touch the array.
          if (req_err || Mout_we_ram) begin
            state_d = S_WR_WAIT;
            cnt_d   = 8'(WRITE_DELAY - 1);
          end else begin
            state_d = S_RD_WAIT;
            cnt_d   = 8'(READ_DELAY - 1);
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = S_RESP;
          rdata_d = rd_word;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_WR_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    M_DataRdy   = (state_q == S_RESP);
    M_Rdata_ram = M_DataRdy ? rdata_q : '0;
    err         = err_q;
    host_rdata  = host_rdata_q;
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder: a byte-array/response-queue model is
// compared against the DUT every cycle, with literal checks pinning key results.
module tb_ext_mem_responder;

  localparam int MEM_BYTES = 1024;
  localparam int RD_DLY    = 2;
  localparam int WR_DLY    = 1;

  logic        clock, reset;
  logic        oe, we;
  logic [31:0] addr;
  logic [15:0] wdata;
  logic [4:0]  size;
  logic [15:0] rdata;
  logic        rdy, err;
  logic        host_en, host_we;
  logic [9:0]  host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic [1:0]  dbg_state;

  ext_mem_responder dut (
    .clock              (clock),
    .reset              (reset),
    .Mout_oe_ram        (oe),
    .Mout_we_ram        (we),
    .Mout_addr_ram      (addr),
    .Mout_Wdata_ram     (wdata),
    .Mout_data_ram_size (size),
    .M_Rdata_ram        (rdata),
    .M_DataRdy          (rdy),
    .err                (err),
    .host_en            (host_en),
    .host_we            (host_we),
    .host_addr          (host_addr),
    .host_wdata         (host_wdata),
    .host_rdata         (host_rdata),
    .dbg_state          (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- model state / scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_from = 1 << 30;
  int          free_edge = 0;
  int          exp_cyc_q[$];
  logic [15:0] exp_q[$];
  int          pulse_cyc_q[$];
  logic [15:0] last_data;
  int          last_cyc;
  logic [7:0]  model_mem [MEM_BYTES];
  logic        cmp_rdy;
  logic [15:0] cmp_d;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      void'(exp_cyc_q.pop_front());
      void'(exp_q.pop_front());
    end
    cmp_rdy = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
    cmp_d   = '0;
    if (cmp_rdy) begin
      void'(exp_cyc_q.pop_front());
      cmp_d = exp_q.pop_front();
    end
    check("datardy", {31'd0, rdy}, {31'd0, cmp_rdy});
    check("rdata", {16'd0, rdata}, {16'd0, cmp_d});
    check("err", {31'd0, err}, (cyc >= err_from) ? 32'd1 : 32'd0);
    if (rdy) begin
      pulse_cyc_q.push_back(cyc);
      last_data = rdata;
      last_cyc  = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic o, input logic w, input logic [31:0] a,
                       input logic [15:0] wd, input logic [4:0] sz, output int e_out);
    int          e, d, nb, idx;
    bit          bad;
    logic [15:0] dexp;
    @(negedge clock);
    oe = o; we = w; addr = a; wdata = wd; size = sz;
    e   = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
    nb  = int'(sz) / 8;
    bad = (o && w) || (sz == 0) || (int'(sz) % 8 != 0) || (int'(sz) > 16) ||
          (longint'(a) + longint'(nb) > longint'(MEM_BYTES));
    idx  = bad ? 0 : int'(a);
    dexp = '0;
    if (!bad && o)
      for (int k = 0; k < nb; k++) dexp = dexp | (16'(model_mem[idx + k]) << (8 * k));
    if (!bad && w)
      for (int k = 0; k < nb; k++) model_mem[idx + k] = wd[8*k +: 8];
    d = (bad || w) ? WR_DLY : RD_DLY;
    if (bad && err_from > e) err_from = e;
    exp_cyc_q.push_back(e + d);
    exp_q.push_back(dexp);
    free_edge = e + d + 1;
    while (cyc < e + d) @(negedge clock);
    oe = 1'b0; we = 1'b0;
    @(negedge clock);
    e_out = e;
  endtask

  task automatic host_wr(input int i, input logic [7:0] b);
    @(negedge clock);
    host_en = 1'b1; host_we = 1'b1; host_addr = 10'(i); host_wdata = b;
    @(negedge clock);
    host_en = 1'b0; host_we = 1'b0;
    model_mem[i] = b;
  endtask

  task automatic host_rd(input int i, input logic [7:0] lit, input string nm);
    @(negedge clock);
    host_en = 1'b1; host_we = 1'b0; host_addr = 10'(i);
    @(negedge clock);
    check({nm, "_model"}, {24'd0, host_rdata}, {24'd0, model_mem[i]});
    check(nm, {24'd0, host_rdata}, {24'd0, lit});
    host_en = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e, e0, n;
    reset = 1'b0; oe = 1'b0; we = 1'b0; addr = '0; wdata = '0; size = '0;
    host_en = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;

    repeat (3) @(negedge clock);
    check("rst_rdy", {31'd0, rdy}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_host_rdata", {24'd0, host_rdata}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // 1: basic 16-bit read
    host_wr(0, 8'h11); host_wr(1, 8'h22); host_wr(2, 8'h33); host_wr(3, 8'h44);
    issue(1'b1, 1'b0, 32'd0, 16'h0, 5'd16, e);
    check("t1_data", {16'd0, last_data}, 32'h2211);
    check("t1_latency", last_cyc - e, 32'd2);
    check("t1_err", {31'd0, err}, 32'd0);

    // 2: 16-bit write, little-endian commit
    issue(1'b0, 1'b1, 32'd2, 16'hBEEF, 5'd16, e);
    check("t2_latency", last_cyc - e, 32'd1);
    check("t2_data", {16'd0, last_data}, 32'd0);
    host_rd(2, 8'hEF, "t2_idx2");
    host_rd(3, 8'hBE, "t2_idx3");

    // 3: byte read, then back-to-back held reads
    issue(1'b1, 1'b0, 32'd1, 16'h0, 5'd8, e);
    check("t3_data", {16'd0, last_data}, 32'h0022);
    @(negedge clock);
    oe = 1'b1; we = 1'b0; addr = 32'd1; size = 5'd8;
    e0 = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      exp_cyc_q.push_back(e0 + RD_DLY + 3 * i);
      exp_q.push_back({8'h00, model_mem[1]});
    end
    while (cyc < e0 + RD_DLY + 6) @(negedge clock);
    oe = 1'b0;
    free_edge = e0 + RD_DLY + 7;
    @(negedge clock);
    n = pulse_cyc_q.size();
    check("t3_gap1", pulse_cyc_q[n-2] - pulse_cyc_q[n-3], 32'd3);
    check("t3_gap2", pulse_cyc_q[n-1] - pulse_cyc_q[n-2], 32'd3);
    check("t3_b2b_data", {16'd0, last_data}, 32'h0022);

    // top-of-array read that just fits
    host_wr(1022, 8'hA5); host_wr(1023, 8'h5A);
    issue(1'b1, 1'b0, 32'd1022, 16'h0, 5'd16, e);
    check("edge_data", {16'd0, last_data}, 32'h5AA5);

    // 4: out-of-range read, then a valid read with err still set
    issue(1'b1, 1'b0, 32'd1023, 16'h0, 5'd16, e);
    check("t4_latency", last_cyc - e, 32'd1);
    check("t4_data", {16'd0, last_data}, 32'd0);
    check("t4_err", {31'd0, err}, 32'd1);
    issue(1'b1, 1'b0, 32'd0, 16'h0, 5'd16, e);
    check("t4_valid_data", {16'd0, last_data}, 32'h2211);
    check("t4_err_sticky", {31'd0, err}, 32'd1);
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 16'h0, 5'd8, e);
    check("t4_wrap_latency", last_cyc - e, 32'd1);

    // 5: oe&we, size 12, size 24 -- no array change
    issue(1'b1, 1'b1, 32'd0, 16'hDEAD, 5'd16, e);
    check("t5_both_latency", last_cyc - e, 32'd1);
    issue(1'b0, 1'b1, 32'd0, 16'hCAFE, 5'd12, e);
    check("t5_sz12_latency", last_cyc - e, 32'd1);
    issue(1'b0, 1'b1, 32'd0, 16'hCAFE, 5'd24, e);
    check("t5_sz24_data", {16'd0, last_data}, 32'd0);
    host_rd(0, 8'h11, "t5_idx0");
    host_rd(1, 8'h22, "t5_idx1");
    host_rd(2, 8'hEF, "t5_idx2");
    host_rd(3, 8'hBE, "t5_idx3");

    // 6: reset during a read wait
    n = pulse_cyc_q.size();
    @(negedge clock);
    oe = 1'b1; we = 1'b0; addr = 32'd0; size = 5'd16;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    err_from = 1 << 30;
    free_edge = 0;
    oe = 1'b0;
    @(negedge clock);
    check("t6_state", {30'd0, dbg_state}, 32'd0);
    check("t6_err", {31'd0, err}, 32'd0);
    check("t6_rdy", {31'd0, rdy}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("t6_no_pulse", pulse_cyc_q.size(), n);
    host_rd(0, 8'h11, "t6_idx0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
